// File: rtl/phys_free_list_pkg.sv
// Shared rename definitions: register-file sizing, the physical tag type and
// the modulo-depth increment used by the free-list pointers.
package phys_free_list_pkg;

  localparam int unsigned NumArchRegs = 35;
  localparam int unsigned NumPhysRegs = 64;
  localparam int unsigned TW          = $clog2(NumPhysRegs);

  typedef logic [TW-1:0] phys_tag_t;

  // Depth need not be a power of two, so wrap explicitly instead of overflowing.
  function automatic int unsigned wrap_inc(int unsigned ptr, int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/phys_free_list_if.sv
// Rename-stage <-> free-list connection: allocate, retire-free, flush and status.
interface phys_free_list_if
  import phys_free_list_pkg::*;
#(
  parameter int unsigned NUM_ARCH_REGS = NumArchRegs,
  parameter int unsigned NUM_PHYS_REGS = NumPhysRegs
);

  localparam int unsigned D    = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int unsigned TagW = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CW   = $clog2(D + 1);

  logic            alloc_req;
  logic            alloc_grant;
  logic [TagW-1:0] alloc_tag;
  logic            retire_valid;
  logic [TagW-1:0] retire_old_tag;
  logic            flush;
  logic [CW-1:0]   free_count;
  logic            empty;
  logic            err;

  modport master (
    output alloc_req,
    output retire_valid,
    output retire_old_tag,
    output flush,
    input  alloc_grant,
    input  alloc_tag,
    input  free_count,
    input  empty,
    input  err
  );

  modport slave (
    input  alloc_req,
    input  retire_valid,
    input  retire_old_tag,
    input  flush,
    output alloc_grant,
    output alloc_tag,
    output free_count,
    output empty,
    output err
  );

endinterface

// File: rtl/phys_free_list_wrap_ptr.sv
// Modulo-Depth pointer with increment and parallel load; load wins over increment.
module fl_wrap_ptr
  import phys_free_list_pkg::*;
#(
  parameter int unsigned Depth = 29,
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] ptr
);

  logic [Width-1:0] ptr_q;
  logic [Width-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = Width'(wrap_inc(32'(ptr_q), Depth));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/phys_free_list.sv
// Physical register free list: circular buffer of free tags with speculative and
// committed allocate pointers so a flush can roll back uncommitted allocations.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int unsigned NUM_ARCH_REGS = NumArchRegs,
  parameter int unsigned NUM_PHYS_REGS = NumPhysRegs
) (
  input  logic                clk,
  input  logic                reset,
  phys_free_list_if.slave     fl
);

  localparam int unsigned D    = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int unsigned TagW = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CW   = $clog2(D + 1);
  localparam int unsigned PW   = (D > 1) ? $clog2(D) : 1;

  logic [PW-1:0]   head;
  logic [PW-1:0]   commit_head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   commit_next;
  logic [TagW-1:0] mem_q [D];
  logic [CW-1:0]   free_count_q;
  logic [CW-1:0]   free_count_d;
  logic            empty_q;
  logic            err_q;
  logic            err_d;
  logic            grant;
  logic            retire_ok;

  // Gated by reset so no grant is visible while the list is being reinitialised.
  assign grant = fl.alloc_req & reset & ~empty_q & ~fl.flush;

  // A full speculative count means nothing is outstanding, so there is nothing to retire.
  assign retire_ok   = fl.retire_valid & (free_count_q != CW'(D));
  assign commit_next = retire_ok ? PW'(wrap_inc(32'(commit_head), D)) : commit_head;

  fl_wrap_ptr #(
    .Depth (D),
    .Width (PW)
  ) u_head (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant),
    .load     (fl.flush),
    .load_val (commit_next),
    .ptr      (head)
  );

  fl_wrap_ptr #(
    .Depth (D),
    .Width (PW)
  ) u_commit_head (
    .clk      (clk),
    .reset    (reset),
    .inc      (retire_ok),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (commit_head)
  );

  fl_wrap_ptr #(
    .Depth (D),
    .Width (PW)
  ) u_tail (
    .clk      (clk),
    .reset    (reset),
    .inc      (retire_ok),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (tail)
  );

  // Every retire commits one allocation and frees one tag, so the committed
  // region (commit_head to tail) always spans all D entries after a flush.
  always_comb begin
    free_count_d = free_count_q;
    if (fl.flush) begin
      free_count_d = CW'(D);
    end else if (grant && !retire_ok) begin
      free_count_d = free_count_q - CW'(1);
    end else if (retire_ok && !grant) begin
      free_count_d = free_count_q + CW'(1);
    end
  end

  assign err_d = err_q | (fl.retire_valid & ~retire_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_count_q <= CW'(D);
      empty_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      free_count_q <= free_count_d;
      empty_q      <= (free_count_d == '0);
      err_q        <= err_d;
    end
  end

  // Reset contents follow the RAT identity map: tags NUM_ARCH_REGS.. are free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(D); i++) begin
        mem_q[i] <= TagW'(int'(NUM_ARCH_REGS) + i);
      end
    end else if (retire_ok) begin
      mem_q[tail] <= fl.retire_old_tag;
    end
  end

  assign fl.alloc_grant = grant;
  assign fl.alloc_tag   = mem_q[head];
  assign fl.free_count  = free_count_q;
  assign fl.empty       = empty_q;
  assign fl.err         = err_q;

  commit_tail_aligned: assert property (@(posedge clk) disable iff (!reset)
    commit_head == tail);

  count_in_range: assert property (@(posedge clk) disable iff (!reset)
    free_count_q <= CW'(D));

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: directed scenarios plus random traffic
// compared every cycle against a queue-based model of free and in-flight tags.
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  localparam int Depth = NumPhysRegs - NumArchRegs;

  logic clk;
  logic reset;

  phys_free_list_if ifc ();

  phys_free_list dut (
    .clk   (clk),
    .reset (reset),
    .fl    (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model: free tags in allocation order, and granted-but-unretired tags oldest first.
  int spec_q[$];
  int inflight_q[$];
  bit m_err;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    spec_q.delete();
    inflight_q.delete();
    for (int i = 0; i < Depth; i++) spec_q.push_back(NumArchRegs + i);
    m_err = 1'b0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      bit legal;
      bit g;
      legal = ifc.retire_valid && (inflight_q.size() > 0);
      if (ifc.retire_valid && !legal) m_err = 1'b1;
      g = ifc.alloc_req && (spec_q.size() > 0) && !ifc.flush;
      if (g) inflight_q.push_back(spec_q.pop_front());
      if (legal) begin
        void'(inflight_q.pop_front());
        spec_q.push_back(int'(ifc.retire_old_tag));
      end
      if (ifc.flush) begin
        for (int i = inflight_q.size() - 1; i >= 0; i--) spec_q.push_front(inflight_q[i]);
        inflight_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_grant", int'(ifc.alloc_grant), 0);
      chk("rst_free_count", int'(ifc.free_count), Depth);
      chk("rst_empty", int'(ifc.empty), 0);
      chk("rst_err", int'(ifc.err), 0);
    end else begin
      bit exp_g;
      exp_g = ifc.alloc_req && (spec_q.size() > 0) && !ifc.flush;
      chk("grant", int'(ifc.alloc_grant), int'(exp_g));
      if (exp_g) chk("tag", int'(ifc.alloc_tag), spec_q[0]);
      chk("free_count", int'(ifc.free_count), spec_q.size());
      chk("empty", int'(ifc.empty), int'(spec_q.size() == 0));
      chk("err", int'(ifc.err), int'(m_err));
    end
  end

  task automatic idle();
    ifc.alloc_req      = 1'b0;
    ifc.retire_valid   = 1'b0;
    ifc.retire_old_tag = '0;
    ifc.flush          = 1'b0;
  endtask

  task automatic step(input bit req, input bit ret, input int tag, input bit fls,
                      output bit g, output int t);
    ifc.alloc_req      = req;
    ifc.retire_valid   = ret;
    ifc.retire_old_tag = TW'(tag);
    ifc.flush          = fls;
    @(negedge clk);
    g = ifc.alloc_grant;
    t = int'(ifc.alloc_tag);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_grant"}, int'(ifc.alloc_grant), 0);
    chk({tag, "_free_count"}, int'(ifc.free_count), 29);
    chk({tag, "_empty"}, int'(ifc.empty), 0);
    chk({tag, "_err"}, int'(ifc.err), 0);
  endtask

  // Asserted mid-cycle; checked before any clock edge to prove asynchronous reset.
  task automatic apply_reset();
    reset = 1'b0;
    #2;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit g;
    int t;
    reset = 1'b1;
    idle();
    ifc.alloc_req = 1'b1;
    #1;
    reset = 1'b0;
    #2;
    check_reset_values("init_rst");
    ifc.alloc_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Three allocations straight out of reset.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, g, t);
      chk("a_grant", int'(g), 1);
      chk("a_tag", t, 35 + i);
    end
    chk("a_free_count", int'(ifc.free_count), 26);

    // Drain the whole list, then one more request is refused.
    apply_reset();
    for (int i = 0; i < 29; i++) begin
      step(1, 0, 0, 0, g, t);
      chk("b_tag", t, 35 + i);
    end
    chk("b_empty", int'(ifc.empty), 1);
    chk("b_free_count", int'(ifc.free_count), 0);
    step(1, 0, 0, 0, g, t);
    chk("b_grant_when_empty", int'(g), 0);
    chk("b_free_count_after", int'(ifc.free_count), 0);

    // Freed tag is not bypassed in its own cycle.
    step(1, 1, 5, 0, g, t);
    chk("c_no_bypass", int'(g), 0);
    chk("c_free_count", int'(ifc.free_count), 1);
    step(1, 0, 0, 0, g, t);
    chk("c_grant", int'(g), 1);
    chk("c_tag", t, 5);

    // Flush rolls back to the committed head.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, g, t);
    step(0, 1, 2, 0, g, t);
    step(0, 0, 0, 1, g, t);
    chk("d_free_count", int'(ifc.free_count), 29);
    step(1, 0, 0, 0, g, t);
    chk("d_tag", t, 36);

    // Retire with nothing outstanding raises a sticky error.
    apply_reset();
    step(0, 1, 9, 0, g, t);
    chk("e_err", int'(ifc.err), 1);
    chk("e_free_count", int'(ifc.free_count), 29);
    step(1, 0, 0, 0, g, t);
    step(1, 0, 0, 0, g, t);
    step(0, 1, 4, 0, g, t);
    step(0, 0, 0, 1, g, t);
    chk("e_err_sticky", int'(ifc.err), 1);
    apply_reset();

    // Reset in the middle of a grant+retire burst.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, g, t);
    for (int i = 0; i < 3; i++) step(1, 1, 10 + i, 0, g, t);
    ifc.alloc_req      = 1'b1;
    ifc.retire_valid   = 1'b1;
    ifc.retire_old_tag = TW'(3);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("f_mid_burst");
    @(posedge clk);
    #1;
    idle();
    reset = 1'b1;

    // Random traffic, alternating between draining and refilling phases.
    for (int c = 0; c < 3000; c++) begin
      bit rq;
      bit rt;
      bit fls;
      int tg;
      rq  = ($urandom_range(0, 9) < (((c / 500) % 2) != 0 ? 9 : 4));
      rt  = (inflight_q.size() > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 49) == 0);
      fls = ($urandom_range(0, 39) == 0);
      tg  = int'($urandom_range(0, NumPhysRegs - 1));
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
      end else begin
        step(rq, rt, tg, fls, g, t);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
